// File: rtl/thermal_overlay_mixer_pkg.sv
// Shared types and colour-mapping helpers for the thermal overlay mixer.
// Packs the overlay mode encoding, the false-colour breakpoints and the per-channel mix functions.
package thermal_overlay_mixer_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GREY   = 2'd1,
    MODE_BLEND  = 2'd2,
    MODE_FALSE  = 2'd3
  } t_overlay_mode;

  localparam logic [7:0] c_fc_knee_lo = 8'd64;
  localparam logic [7:0] c_fc_knee_hi = 8'd128;

  // 9-bit sum keeps the carry so 0xFF + 0xFF averages back to 0xFF.
  function automatic logic [7:0] blend_ch(input logic [7:0] cam, input logic [7:0] v);
    logic [8:0] sum;
    sum = {1'b0, cam} + {1'b0, v};
    return sum[8:1];
  endfunction

  function automatic logic [23:0] false_colour(input logic [7:0] v);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    if (v >= c_fc_knee_hi) r = 8'hFF;
    else                   r = 8'(v << 1);
    if (v < c_fc_knee_hi)  g = 8'h00;
    else                   g = 8'((v - c_fc_knee_hi) << 1);
    if (v < c_fc_knee_lo)       b = 8'(v << 2);
    else if (v < c_fc_knee_hi)  b = 8'((8'd127 - v) << 2);
    else                        b = 8'h00;
    return {r, g, b};
  endfunction

endpackage

// File: rtl/thermal_overlay_mixer_delay_line.sv
// Fixed-depth shift register used to align camera data and timing with the framebuffer read.
module overlay_delay_line #(
  parameter int p_width = 8,
  parameter int p_depth = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [p_width-1:0] d,
  output logic [p_width-1:0] q
);

  logic [p_depth-1:0][p_width-1:0] pipe_r;

  generate
    if (p_depth == 1) begin : g_single
      // Single-stage register.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pipe_r <= '0;
        else          pipe_r <= d;
      end
    end else begin : g_multi
      // Shift toward the top index; the oldest sample sits at p_depth-1.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pipe_r <= '0;
        else          pipe_r <= {pipe_r[p_depth-2:0], d};
      end
    end
  endgenerate

  assign q = pipe_r[p_depth-1];

endmodule

// File: rtl/thermal_overlay_mixer.sv
// Overlays an upscaled thermal frame onto the camera video stream.
// Stage 0 issues the framebuffer read; the mix stage combines the returned sample with delayed video.
module thermal_overlay_mixer
  import thermal_overlay_mixer_pkg::*;
#(
  parameter int p_src_w      = 32,
  parameter int p_src_h      = 24,
  parameter int p_scale_log2 = 3,
  parameter int p_rd_latency = 1,
  localparam int c_addrw     = $clog2(p_src_w * p_src_h)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_hsync,
  input  logic                i_vsync,
  input  logic                i_de,
  input  logic signed [15:0]  i_x_pos,
  input  logic signed [15:0]  i_y_pos,
  input  logic [2:0][7:0]     i_cam_data,
  input  logic [1:0]          i_mode,
  input  logic                i_hflip,
  input  logic                i_vflip,
  input  logic [15:0]         i_origin_x,
  input  logic [15:0]         i_origin_y,
  output logic                o_fb_rd_valid,
  output logic [c_addrw-1:0]  o_fb_rd_addr,
  input  logic [7:0]          i_fb_rd_data,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_de,
  output logic [2:0][7:0]     o_data
);

  localparam int c_dly   = 1 + p_rd_latency;
  localparam int c_dly_w = 30;

  logic          vsync_d_r;
  logic          cfg_load_r;
  t_overlay_mode mode_r;
  logic          hflip_r;
  logic          vflip_r;
  logic [15:0]   origin_x_r;
  logic [15:0]   origin_y_r;

  // Frame-boundary shadow of the configuration, loaded the cycle after a vsync rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_d_r  <= 1'b0;
      cfg_load_r <= 1'b0;
      mode_r     <= MODE_BYPASS;
      hflip_r    <= 1'b0;
      vflip_r    <= 1'b0;
      origin_x_r <= 16'd0;
      origin_y_r <= 16'd0;
    end else begin
      vsync_d_r  <= i_vsync;
      cfg_load_r <= i_vsync & ~vsync_d_r;
      if (cfg_load_r) begin
        mode_r     <= t_overlay_mode'(i_mode);
        hflip_r    <= i_hflip;
        vflip_r    <= i_vflip;
        origin_x_r <= i_origin_x;
        origin_y_r <= i_origin_y;
      end else begin
        mode_r     <= mode_r;
        hflip_r    <= hflip_r;
        vflip_r    <= vflip_r;
        origin_x_r <= origin_x_r;
        origin_y_r <= origin_y_r;
      end
    end
  end

  logic [17:0]        dx_s;
  logic [17:0]        dy_s;
  logic [17:0]        sx_s;
  logic [17:0]        sy_s;
  logic [17:0]        sx_f_s;
  logic [17:0]        sy_f_s;
  logic               in_win_s;
  logic               rd_hit_s;
  logic [c_addrw-1:0] rd_addr_s;

  // Window test and flipped address; 18-bit arithmetic so a signed x minus an unsigned origin cannot wrap.
  always_comb begin
    dx_s     = {{2{i_x_pos[15]}}, i_x_pos} - {2'b00, origin_x_r};
    dy_s     = {{2{i_y_pos[15]}}, i_y_pos} - {2'b00, origin_y_r};
    sx_s     = dx_s >> p_scale_log2;
    sy_s     = dy_s >> p_scale_log2;
    in_win_s = !dx_s[17] && !dy_s[17] &&
               (sx_s < 18'(p_src_w)) && (sy_s < 18'(p_src_h));
    if (hflip_r) sx_f_s = 18'(p_src_w - 1) - sx_s;
    else         sx_f_s = sx_s;
    if (vflip_r) sy_f_s = 18'(p_src_h - 1) - sy_s;
    else         sy_f_s = sy_s;
    rd_addr_s = c_addrw'(sy_f_s * 18'(p_src_w) + sx_f_s);
    rd_hit_s  = in_win_s && i_de && (mode_r != MODE_BYPASS);
  end

  logic               fb_rd_valid_r;
  logic [c_addrw-1:0] fb_rd_addr_r;

  // Framebuffer request; the address holds whenever no read is issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fb_rd_valid_r <= 1'b0;
      fb_rd_addr_r  <= '0;
    end else begin
      fb_rd_valid_r <= rd_hit_s;
      if (rd_hit_s) fb_rd_addr_r <= rd_addr_s;
      else          fb_rd_addr_r <= fb_rd_addr_r;
    end
  end

  assign o_fb_rd_valid = fb_rd_valid_r;
  assign o_fb_rd_addr  = fb_rd_addr_r;

  logic [c_dly_w-1:0] dly_in_s;
  logic [c_dly_w-1:0] dly_out_s;
  logic               hsync_d_s;
  logic               vsync_dd_s;
  logic               de_d_s;
  logic               in_win_d_s;
  logic [1:0]         mode_d_s;
  logic [2:0][7:0]    cam_d_s;

  // Mode travels with the pixel so a shadow update never splits a pixel from its mix rule.
  assign dly_in_s = {i_hsync, i_vsync, i_de, in_win_s, mode_r, i_cam_data};
  assign {hsync_d_s, vsync_dd_s, de_d_s, in_win_d_s, mode_d_s, cam_d_s} = dly_out_s;

  overlay_delay_line #(
    .p_width (c_dly_w),
    .p_depth (c_dly)
  ) u_align (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .d       (dly_in_s),
    .q       (dly_out_s)
  );

  logic [2:0][7:0] mix_s;

  // Per-pixel mix of aligned camera data with the returned thermal sample.
  always_comb begin
    mix_s = '0;
    if (!de_d_s) begin
      mix_s = '0;
    end else if (in_win_d_s && (mode_d_s != 2'd0)) begin
      case (t_overlay_mode'(mode_d_s))
        MODE_GREY:  mix_s = {i_fb_rd_data, i_fb_rd_data, i_fb_rd_data};
        MODE_BLEND: mix_s = {blend_ch(cam_d_s[2], i_fb_rd_data),
                             blend_ch(cam_d_s[1], i_fb_rd_data),
                             blend_ch(cam_d_s[0], i_fb_rd_data)};
        MODE_FALSE: mix_s = false_colour(i_fb_rd_data);
        default:    mix_s = cam_d_s;
      endcase
    end else begin
      mix_s = cam_d_s;
    end
  end

  logic            hsync_r;
  logic            vsync_r;
  logic            de_r;
  logic [2:0][7:0] data_r;

  // Output register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
      de_r    <= 1'b0;
      data_r  <= '0;
    end else begin
      hsync_r <= hsync_d_s;
      vsync_r <= vsync_dd_s;
      de_r    <= de_d_s;
      data_r  <= mix_s;
    end
  end

  assign o_hsync = hsync_r;
  assign o_vsync = vsync_r;
  assign o_de    = de_r;
  assign o_data  = data_r;

endmodule

// File: tb/tb_thermal_overlay_mixer.sv
// Table-driven scoreboard bench for thermal_overlay_mixer with a latency-1 framebuffer model.
module tb_thermal_overlay_mixer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic signed [15:0] x = 16'sd0, y = 16'sd0;
  logic [23:0]        cam = 24'h0;
  logic [1:0]         mode = 2'd0;
  logic               hf = 1'b0, vf = 1'b0;
  logic [15:0]        ox = 16'd0, oy = 16'd0;
  logic               rd_valid;
  logic [9:0]         rd_addr;
  logic [7:0]         fb_data = 8'h0;
  logic               hs_o, vs_o, de_o;
  logic [23:0]        data_o;

  int errors = 0;
  int n_checks = 0;
  int cyc = 0;

  logic [7:0] fb_mem [0:767];

  thermal_overlay_mixer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .i_x_pos(x), .i_y_pos(y), .i_cam_data(cam), .i_mode(mode),
    .i_hflip(hf), .i_vflip(vf), .i_origin_x(ox), .i_origin_y(oy),
    .o_fb_rd_valid(rd_valid), .o_fb_rd_addr(rd_addr), .i_fb_rd_data(fb_data),
    .o_hsync(hs_o), .o_vsync(vs_o), .o_de(de_o), .o_data(data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) fb_data <= fb_mem[rd_addr];

  typedef struct {
    logic [1:0]  mode; logic hf; logic vf; logic [15:0] ox; logic [15:0] oy;
    logic signed [15:0] x; logic signed [15:0] y; logic hs; logic de;
    logic [23:0] cam; logic [7:0] fbv; logic ev; logic [9:0] ea; logic [23:0] ed;
  } vec_t;
  typedef struct { int due; logic ev; logic [9:0] ea; string tag; } aexp_t;
  typedef struct { int due; logic [23:0] ed; logic hs; logic de; string tag; } dexp_t;

  vec_t  tv[$];
  aexp_t aq[$];
  dexp_t dq[$];
  logic [1:0]  cur_mode = 2'd0;
  logic        cur_hf = 1'b0, cur_vf = 1'b0;
  logic [15:0] cur_ox = 16'd0, cur_oy = 16'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic h, input logic v,
                              input int oxx, input int oyy, input int xx, input int yy,
                              input logic hsv, input logic dev, input logic [23:0] c,
                              input logic [7:0] fbv, input logic ev, input int ea,
                              input logic [23:0] ed);
    vec_t r;
    r.mode = m; r.hf = h; r.vf = v; r.ox = 16'(oxx); r.oy = 16'(oyy);
    r.x = 16'(xx); r.y = 16'(yy); r.hs = hsv; r.de = dev; r.cam = c;
    r.fbv = fbv; r.ev = ev; r.ea = 10'(ea); r.ed = ed;
    return r;
  endfunction

  // Scoreboard: pop expectations whose due cycle has come.
  always @(negedge clk) begin
    aexp_t a;
    dexp_t d;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      a = aq.pop_front();
      check({a.tag, " rd_valid"}, {31'd0, rd_valid}, {31'd0, a.ev});
      check({a.tag, " rd_addr"}, {22'd0, rd_addr}, {22'd0, a.ea});
    end
    while (dq.size() > 0 && dq[0].due <= cyc) begin
      d = dq.pop_front();
      check({d.tag, " data"}, {8'd0, data_o}, {8'd0, d.ed});
      check({d.tag, " hsync"}, {31'd0, hs_o}, {31'd0, d.hs});
      check({d.tag, " vsync"}, {31'd0, vs_o}, 32'd0);
      check({d.tag, " de"}, {31'd0, de_o}, {31'd0, d.de});
    end
  end

  task automatic drive_vec(input vec_t v, input string tag);
    aexp_t a;
    dexp_t d;
    @(posedge clk); #1;
    mode = v.mode; hf = v.hf; vf = v.vf; ox = v.ox; oy = v.oy;
    x = v.x; y = v.y; hs = v.hs; vs = 1'b0; de = v.de; cam = v.cam;
    if (v.ev) fb_mem[v.ea] = v.fbv;
    a.due = cyc + 1; a.ev = v.ev; a.ea = v.ea; a.tag = tag;
    d.due = cyc + 3; d.ed = v.ed; d.hs = v.hs; d.de = v.de; d.tag = tag;
    aq.push_back(a);
    dq.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      hs = 1'b0; vs = 1'b0; de = 1'b0; cam = 24'h0; x = 16'sd0; y = 16'sd0;
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic h, input logic v,
                         input logic [15:0] oxx, input logic [15:0] oyy);
    @(posedge clk); #1;
    mode = m; hf = h; vf = v; ox = oxx; oy = oyy; de = 1'b0; hs = 1'b0; vs = 1'b1;
    @(posedge clk); #1;
    vs = 1'b0;
    cur_mode = m; cur_hf = h; cur_vf = v; cur_ox = oxx; cur_oy = oyy;
    idle(5);
  endtask

  initial begin
    for (int i = 0; i < 768; i++) fb_mem[i] = 8'h00;

    // grey replace, defaults
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 0, 0,   9,  17, 1'b0, 1'b1, 24'h112233, 8'h5A, 1'b1,  65, 24'h5A5A5A));
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 0, 0, 255, 191, 1'b0, 1'b1, 24'h445566, 8'h11, 1'b1, 767, 24'h111111));
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 0, 0, 256,   0, 1'b1, 1'b1, 24'hA1B2C3, 8'h00, 1'b0, 767, 24'hA1B2C3));
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 0, 0,   0, 192, 1'b0, 1'b1, 24'h010203, 8'h00, 1'b0, 767, 24'h010203));
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 0, 0,  -1,   5, 1'b0, 1'b1, 24'h0F0E0D, 8'h00, 1'b0, 767, 24'h0F0E0D));
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 0, 0,   9,  17, 1'b0, 1'b0, 24'h777777, 8'h00, 1'b0, 767, 24'h000000));
    // both flips
    tv.push_back(mk(2'd1, 1'b1, 1'b1, 0, 0,   0,   0, 1'b0, 1'b1, 24'h000000, 8'h77, 1'b1, 767, 24'h777777));
    tv.push_back(mk(2'd1, 1'b1, 1'b1, 0, 0, 256,   0, 1'b1, 1'b1, 24'h00FF00, 8'h00, 1'b0, 767, 24'h00FF00));
    tv.push_back(mk(2'd1, 1'b1, 1'b1, 0, 0,   8,   8, 1'b0, 1'b1, 24'h123456, 8'h40, 1'b1, 734, 24'h404040));
    // false colour across both knees
    tv.push_back(mk(2'd3, 1'b0, 1'b0, 0, 0,  16,   0, 1'b0, 1'b1, 24'h555555, 8'h30, 1'b1,   2, 24'h6000C0));
    tv.push_back(mk(2'd3, 1'b0, 1'b0, 0, 0,  24,   0, 1'b0, 1'b1, 24'h555555, 8'hC8, 1'b1,   3, 24'hFF9000));
    tv.push_back(mk(2'd3, 1'b0, 1'b0, 0, 0,  32,   0, 1'b0, 1'b1, 24'h555555, 8'h50, 1'b1,   4, 24'hA000BC));
    tv.push_back(mk(2'd3, 1'b0, 1'b0, 0, 0,  40,   0, 1'b0, 1'b1, 24'h555555, 8'h80, 1'b1,   5, 24'hFF0000));
    tv.push_back(mk(2'd3, 1'b0, 1'b0, 0, 0,  48,   0, 1'b0, 1'b1, 24'h555555, 8'h40, 1'b1,   6, 24'h8000FC));
    tv.push_back(mk(2'd3, 1'b0, 1'b0, 0, 0,  56,   0, 1'b0, 1'b1, 24'h555555, 8'h3F, 1'b1,   7, 24'h7E00FC));
    // blend
    tv.push_back(mk(2'd2, 1'b0, 1'b0, 0, 0,   0,   0, 1'b0, 1'b1, 24'hFFFFFF, 8'hFF, 1'b1,   0, 24'hFFFFFF));
    tv.push_back(mk(2'd2, 1'b0, 1'b0, 0, 0,   8,   0, 1'b0, 1'b1, 24'h102030, 8'h31, 1'b1,   1, 24'h202830));
    tv.push_back(mk(2'd2, 1'b0, 1'b0, 0, 0,  16,   0, 1'b0, 1'b1, 24'h00FF01, 8'h00, 1'b1,   2, 24'h007F00));
    // bypass
    tv.push_back(mk(2'd0, 1'b0, 1'b0, 0, 0,   9,  17, 1'b0, 1'b1, 24'h3C3C3C, 8'h00, 1'b0,   2, 24'h3C3C3C));
    // shifted origin
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 100, 50,  99, 60, 1'b0, 1'b1, 24'hABCDEF, 8'h00, 1'b0,  2, 24'hABCDEF));
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 100, 50, 100, 50, 1'b0, 1'b1, 24'h000000, 8'h9C, 1'b1,  0, 24'h9C9C9C));
    tv.push_back(mk(2'd1, 1'b0, 1'b0, 100, 50, 115, 58, 1'b0, 1'b1, 24'h000000, 8'h21, 1'b1, 33, 24'h212121));

    // Reset held with an active input stream.
    mode = 2'd1; x = 16'sd9; y = 16'sd17; de = 1'b1; cam = 24'hFFFFFF; vs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      hs = ~hs;
    end
    @(negedge clk);
    check("reset data", {8'd0, data_o}, 32'd0);
    check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset rd_addr", {22'd0, rd_addr}, 32'd0);
    check("reset hsync", {31'd0, hs_o}, 32'd0);
    check("reset vsync", {31'd0, vs_o}, 32'd0);
    check("reset de", {31'd0, de_o}, 32'd0);
    @(posedge clk); #1;
    vs = 1'b0; hs = 1'b0; de = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Input mode is 1 but no vsync rise yet: still bypass.
    drive_vec(mk(2'd1, 1'b0, 1'b0, 0, 0, 9, 17, 1'b0, 1'b1, 24'h123456, 8'h5A, 1'b0, 0, 24'h123456), "post-reset bypass");
    idle(4);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].mode != cur_mode || tv[i].hf != cur_hf || tv[i].vf != cur_vf ||
          tv[i].ox != cur_ox || tv[i].oy != cur_oy)
        set_cfg(tv[i].mode, tv[i].hf, tv[i].vf, tv[i].ox, tv[i].oy);
      drive_vec(tv[i], $sformatf("vec%0d", i));
    end
    idle(4);

    // Mid-frame mode change is ignored until the next vsync rise.
    set_cfg(2'd1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive_vec(mk(2'd3, 1'b0, 1'b0, 0, 0, 9, 17, 1'b0, 1'b1, 24'h0, 8'h5A, 1'b1, 65, 24'h5A5A5A), "midframe hold");
    idle(4);
    set_cfg(2'd3, 1'b0, 1'b0, 16'd0, 16'd0);
    drive_vec(mk(2'd3, 1'b0, 1'b0, 0, 0, 9, 17, 1'b0, 1'b1, 24'h0, 8'h5A, 1'b1, 65, 24'hB40094), "midframe applied");

    for (int g = 0; g < 20 && (aq.size() > 0 || dq.size() > 0); g++) @(posedge clk);
    n_checks++;
    if (aq.size() > 0 || dq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", aq.size() + dq.size());
    end

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk); #1;
    x = -16'sd5; y = 16'sd0; de = 1'b1; hs = 1'b1; cam = 24'hA5A5A5;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre-reset data", {8'd0, data_o}, 32'h00A5A5A5);
    check("pre-reset de", {31'd0, de_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset data", {8'd0, data_o}, 32'd0);
    check("async reset de", {31'd0, de_o}, 32'd0);
    check("async reset hsync", {31'd0, hs_o}, 32'd0);
    check("async reset rd_valid", {31'd0, rd_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/thermal_overlay_mixer.md
THERMAL_OVERLAY_MIXER -- requirements
Module: thermal_overlay_mixer

Interface
REQ-001 SHALL have parameter p_src_w, default 32: thermal frame width in pixels.
REQ-002 SHALL have parameter p_src_h, default 24: thermal frame height in pixels.
REQ-003 SHALL have parameter p_scale_log2, default 3: upscale factor of 2^p_scale_log2 in each axis.
REQ-004 SHALL have parameter p_rd_latency, default 1, legal range 1..3: framebuffer read latency in cycles.
REQ-005 SHALL have derived constant c_addrw = $clog2(p_src_w*p_src_h).
REQ-006 SHALL have ports: i_clk  in  1  pixel clock, the only clock in the block.
REQ-007 SHALL have ports: i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 SHALL have ports: i_hsync, i_vsync, i_de  in  1 each  VGA timing from the camera pipeline.
REQ-009 SHALL have ports: i_x_pos, i_y_pos  in  16 signed each  current raster coordinate.
REQ-010 SHALL have ports: i_cam_data  in  3x8  camera RGB.
REQ-011 SHALL have ports: i_mode  in  2  overlay mode, with 0 = bypass, 1 = grey replace, 2 = 50% blend, 3 = false colour.
REQ-012 SHALL have ports: i_hflip, i_vflip  in  1 each  mirror controls.
REQ-013 SHALL have ports: i_origin_x, i_origin_y  in  16 unsigned each  top-left corner of the overlay window.
REQ-014 SHALL have ports: o_fb_rd_valid  out  1, and o_fb_rd_addr  out  c_addrw.
REQ-015 SHALL have ports: i_fb_rd_data  in  8  thermal sample.
REQ-016 SHALL have ports: o_hsync, o_vsync, o_de  out  1 each.
REQ-017 SHALL have ports: o_data  out  3x8.

Function
REQ-018 SHALL sample i_mode, i_hflip, i_vflip, i_origin_x and i_origin_y into shadow registers only in the cycle after a rising edge of i_vsync, so that configuration changes take effect on frame boundaries only.
REQ-019 Stage 0 SHALL compute dx = x - origin_x and dy = y - origin_y, plus sx = dx >> p_scale_log2 and sy = dy >> p_scale_log2.
REQ-020 Stage 0 SHALL assert in_win when dx >= 0, dy >= 0, sx < p_src_w and sy < p_src_h; negative coordinates SHALL never hit the window.
REQ-021 Flip SHALL be applied as sx' = p_src_w-1-sx when hflip is set, and sy' = p_src_h-1-sy when vflip is set.
REQ-022 Address SHALL be o_fb_rd_addr = sy'*p_src_w + sx', registered.
REQ-023 o_fb_rd_valid SHALL equal in_win & i_de & (mode != 0); o_fb_rd_addr SHALL hold its previous value when o_fb_rd_valid is low.
REQ-024 The block SHALL delay i_cam_data, in_win and the sync/de signals by 1 + p_rd_latency cycles so that they align with i_fb_rd_data.
REQ-025 The mix stage SHALL register its output; total latency from input to output SHALL be p_rd_latency + 2 cycles for every output.
REQ-026 Mix, for windowed pixels (in_win with mode != 0) only:
- grey replace: R = G = B = v;
- blend: each channel = (cam + v) >> 1, computed with a 9-bit intermediate so no overflow occurs;
- false colour: R = v >= 128 ? 255 : v << 1; G = v < 128 ? 0 : (v - 128) << 1; B = v < 64 ? v << 2 : v < 128 ? (127 - v) << 2 : 0.
REQ-027 Outside the window, or when mode = 0, o_data SHALL equal the delayed i_cam_data unchanged.
REQ-028 When delayed de is low, o_data SHALL be 0.
REQ-029 o_hsync and o_vsync SHALL keep their input polarity and never be gated.

Reset
REQ-030 While i_rst_n is low, all outputs and all pipeline registers SHALL be 0.
REQ-031 While i_rst_n is low, the shadow configuration SHALL be: mode 0, no flips, origin (0,0).
REQ-032 Reset asserted mid-frame SHALL clear the output within the same clock period (asynchronous assert).
REQ-033 After release, the output SHALL pass through in bypass until the first i_vsync rising edge after release.

Structure
REQ-034 The package SHALL hold the mode enum t_overlay_mode and the false-colour breakpoints (64, 128).
REQ-035 The block SHALL contain one sub-module, overlay_delay_line (parametrised width and depth, async active-low reset), used for the sync/de/camera/in_win alignment.

Verification
REQ-036 Reset check: hold i_rst_n = 0 for 5 cycles with active input -> o_data = 0, o_fb_rd_valid = 0, o_hsync = o_vsync = o_de = 0.
REQ-037 Replace, defaults: mode 1, origin (0,0), no flips, x = 9, y = 17 -> o_fb_rd_addr = 2*32 + 1 = 65; with fb data 0x5A, o_data = {5A,5A,5A} exactly 3 cycles after the input (p_rd_latency = 1).
REQ-038 Flip/edge: hflip = 1, vflip = 1, x = 0, y = 0 -> addr = 23*32 + 31 = 767; x = 256 -> out of window, camera data passes through.
REQ-039 False colour and blend:
- v = 0x30 -> o_data = {60,00,C0};
- v = 0xC8 -> o_data = {FF,90,00};
- blend with cam 0xFF and v = 0xFF -> 0xFF.
REQ-040 Frame-synchronous config: change i_mode mid-frame -> output mode unchanged until after the next i_vsync rise; with origin (100,50) and x = 99 -> not windowed.
